alu_arbiter: RTL
================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have port: clk  input  1  single clock, all state updates on rising edge.
REQ-002 SHALL have port: rst_n  input  1  reset, synchronous, active-low.
REQ-003 SHALL have ports: reqN_valid  input  1  requester N (N=0,1) has an operation pending.
REQ-004 SHALL have ports: reqN_op  input  3  requester N opcode (000 ADD, 001 SUB, 010 AND, 011 NOT, 100 ISZERO).
REQ-005 SHALL have ports: reqN_a, reqN_b  input  8  requester N operands.
REQ-006 SHALL have ports: reqN_ready  output  1  requester N operation accepted this cycle.
REQ-007 SHALL have ports: respN_valid  output  1  one-cycle pulse, result for requester N valid.
REQ-008 SHALL have ports: resp_result  output  8  result; resp_zero  output  1  result==0.
REQ-009 SHALL have ports: alu_control  output  3, alu_srcA  output  8, alu_srcB  output  8  to shared ALU.
REQ-010 SHALL have ports: alu_result  input  8, alu_zero  input  1  from shared ALU (combinational).
REQ-011 SHALL have port: busy  output  1  high in any state other than IDLE.

Function
REQ-012 SHALL implement FSM states IDLE, EXEC, DONE; one operation in flight at a time.
REQ-013 IDLE: if no reqN_valid, stay IDLE; else select winner, go EXEC next cycle.
REQ-014 reqN_ready SHALL be combinational: high only in IDLE, only for the winner, only while its valid is high; transfer = valid && ready.
REQ-015 On transfer, op/a/b and winner id SHALL be latched into internal registers; requester must hold valid and operands stable until ready.
REQ-016 alu_control/alu_srcA/alu_srcB SHALL be driven from the latched registers at all times (never directly from requester inputs).
REQ-017 EXEC: alu_result and alu_zero SHALL be captured into resp_result/resp_zero at end of the cycle; go DONE.
REQ-018 DONE: respN_valid for the latched winner SHALL be high for exactly one cycle; go IDLE.
REQ-019 Latency: transfer in cycle T -> resp pulse in cycle T+2; max throughput one operation per 3 cycles.
REQ-020 resp_result/resp_zero SHALL hold their value until the next EXEC capture.
REQ-021 Opcodes 101-111 SHALL be accepted; in EXEC the capture SHALL force resp_result=8'h00, resp_zero=1 (ALU output ignored).
REQ-022 Simultaneous valid on both requesters: arbitration per REQ-027/REQ-028; loser's ready stays low, its request remains pending.
REQ-023 Request asserting valid while busy SHALL wait; no accept until FSM returns to IDLE.
REQ-024 A requester may re-request in the IDLE cycle immediately following its DONE.

Reset
REQ-025 With rst_n low at a clock edge: state=IDLE, latched op/a/b=0 (alu_control=000, alu_srcA=alu_srcB=8'h00), resp_result=8'h00, resp_zero=1, respN_valid=0, busy=0, last-grant=1.
REQ-026 Reset during EXEC or DONE SHALL drop the in-flight operation; no respN_valid pulse shall follow for it.

Configuration
REQ-027 Macro ALU_ARB_ROUND_ROBIN_EN defined: on contention, winner = requester not granted last; last-grant register updated on each transfer; reset value 1 so requester 0 wins the first tie.
REQ-028 Macro ALU_ARB_ROUND_ROBIN_EN undefined: fixed priority, requester 0 always wins contention; last-grant register absent.

Verification
REQ-029 Single op: req0 ADD a=8'h05 b=8'h03 -> req0_ready at T, resp0_valid at T+2, resp_result=8'h08, resp_zero=0.
REQ-030 Wrap/zero: req1 SUB a=8'h10 b=8'h10 -> resp1_valid, resp_result=8'h00, resp_zero=1; ADD 8'hFF+8'h01 -> 8'h00, zero=1.
REQ-031 Contention, RR_EN defined: both valid continuously with distinct ops -> grants alternate 0,1,0,1, each resp 3 cycles apart; RR_EN undefined -> req0 granted every time, req1 starved.
REQ-032 Ops: NOT a=8'hA5 -> 8'h5A; AND 8'hF0&8'h3C -> 8'h30; ISZERO a=8'h00 -> 8'h01, a=8'h07 -> 8'h00; op=3'b110 -> 8'h00, zero=1.
REQ-033 Reset mid-op: rst_n low in EXEC cycle -> no resp pulse, busy=0, outputs at REQ-025 values next cycle.
REQ-034 Stall: req1 valid asserted during req0's EXEC -> req1_ready stays low until IDLE, then accepted; its operands unchanged in result.

Source files
------------

// File: rtl/alu_arbiter.sv
// alu_arbiter: two-requester front end for one shared combinational ALU.
// One operation is in flight at a time: IDLE (arbitrate/accept) -> EXEC
// (ALU evaluates the latched operands, result captured) -> DONE (one-cycle
// response pulse to the requester that was granted).
// Optional feature macro: ALU_ARB_ROUND_ROBIN_EN (round-robin tie-break;
// when undefined requester 0 has fixed priority).
// Handshake: a request transfers on the rising edge where reqN_valid and
// reqN_ready are both high; the requester holds valid and operands stable
// until then. respN_valid is a single-cycle pulse with no back-pressure.
module alu_arbiter (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       req0_valid,
   input  logic [2:0] req0_op,
   input  logic [7:0] req0_a,
   input  logic [7:0] req0_b,
   output logic       req0_ready,
   input  logic       req1_valid,
   input  logic [2:0] req1_op,
   input  logic [7:0] req1_a,
   input  logic [7:0] req1_b,
   output logic       req1_ready,
   output logic       resp0_valid,
   output logic       resp1_valid,
   output logic [7:0] resp_result,
   output logic       resp_zero,
   output logic [2:0] alu_control,
   output logic [7:0] alu_srcA,
   output logic [7:0] alu_srcB,
   input  logic [7:0] alu_result,
   input  logic       alu_zero,
   output logic       busy,
   output logic [1:0] state_dbg
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t     state_q, state_d;
   logic [2:0] op_q, op_d;
   logic [7:0] a_q, a_d;
   logic [7:0] b_q, b_d;
   logic       winner_q, winner_d;
   logic [7:0] res_q, res_d;
   logic       zero_q, zero_d;
   logic       win_id;
   logic       op_reserved;
`ifdef ALU_ARB_ROUND_ROBIN_EN
   logic       last_q, last_d;
`endif

   // Winner selection among currently valid requesters.
   always_comb begin
      win_id = 1'b0;
      if (req0_valid && req1_valid) begin
`ifdef ALU_ARB_ROUND_ROBIN_EN
         win_id = ~last_q;
`else
         win_id = 1'b0;
`endif
      end else if (req1_valid) begin
         win_id = 1'b1;
      end
   end

   // Opcodes 101..111 are accepted but produce a forced zero result.
   assign op_reserved = op_q[2] & (op_q[1] | op_q[0]);

   // Next-state, latch and handshake logic.
   always_comb begin
      state_d     = state_q;
      op_d        = op_q;
      a_d         = a_q;
      b_d         = b_q;
      winner_d    = winner_q;
      res_d       = res_q;
      zero_d      = zero_q;
      req0_ready  = 1'b0;
      req1_ready  = 1'b0;
      resp0_valid = 1'b0;
      resp1_valid = 1'b0;
`ifdef ALU_ARB_ROUND_ROBIN_EN
      last_d      = last_q;
`endif
      case (state_q)
         IDLE: begin
            if (req0_valid || req1_valid) begin
               req0_ready = ~win_id & req0_valid;
               req1_ready = win_id & req1_valid;
               op_d       = win_id ? req1_op : req0_op;
               a_d        = win_id ? req1_a  : req0_a;
               b_d        = win_id ? req1_b  : req0_b;
               winner_d   = win_id;
`ifdef ALU_ARB_ROUND_ROBIN_EN
               last_d     = win_id;
`endif
               state_d    = EXEC;
            end
         end
         EXEC: begin
            if (op_reserved) begin
               res_d  = 8'h00;
               zero_d = 1'b1;
            end else begin
               res_d  = alu_result;
               zero_d = alu_zero;
            end
            state_d = DONE;
         end
         DONE: begin
            resp0_valid = ~winner_q;
            resp1_valid = winner_q;
            state_d     = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers; reset drops any in-flight operation.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         op_q     <= 3'b000;
         a_q      <= 8'h00;
         b_q      <= 8'h00;
         winner_q <= 1'b0;
         res_q    <= 8'h00;
         zero_q   <= 1'b1;
`ifdef ALU_ARB_ROUND_ROBIN_EN
         last_q   <= 1'b1;
`endif
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         a_q      <= a_d;
         b_q      <= b_d;
         winner_q <= winner_d;
         res_q    <= res_d;
         zero_q   <= zero_d;
`ifdef ALU_ARB_ROUND_ROBIN_EN
         last_q   <= last_d;
`endif
      end
   end

   assign alu_control = op_q;
   assign alu_srcA    = a_q;
   assign alu_srcB    = b_q;
   assign resp_result = res_q;
   assign resp_zero   = zero_q;
   assign busy        = (state_q != IDLE);
   assign state_dbg   = state_q;

endmodule
